button_debounce: RTL
====================

// Module: button_debounce
// PURPOSE
//   Conditions the raw push-button input for the guess-which-hand game FSM.
//   Synchronises the asynchronous pad signal, rejects contact bounce, and emits a clean level plus single-cycle press/release strobes.
//   Sits directly upstream of the game FSM; btn_level drives the FSM's B input.
// PARAMETERS
//   SYNC_STAGES      2    flops in synchroniser chain (>=2)
//   DEBOUNCE_CYCLES  16   consecutive stable synced cycles required to accept a new level (>=2)
//   LONG_CYCLES      64   held-high cycles before btn_long fires (used only with LONG_PRESS_EN)
// PORTS
//   clk          in   1  single system clock, all logic on posedge
//   rst          in   1  synchronous, active-high reset
//   btn_raw      in   1  asynchronous raw button pad, 1 = pressed
//   btn_level    out  1  debounced, registered button level (feeds game FSM B)
//   btn_press    out  1  1-cycle strobe, coincident with btn_level 0->1
//   btn_release  out  1  1-cycle strobe, coincident with btn_level 1->0
//   btn_long     out  1  1-cycle long-press strobe (0 when feature compiled out)
// BEHAVIOUR
//   - Reset (sampled on clk while rst=1): sync chain=0, state=STABLE_LO, counter=0, all outputs 0.
//   - rst has priority over every other event; reset mid-WAIT aborts with no strobe.
//   - Synchroniser: btn_s = btn_raw delayed SYNC_STAGES flops; FSM sees only btn_s.
//   - FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
//     STABLE_LO: btn_s=1 -> WAIT_HI, cnt=1.
//     WAIT_HI: btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI, btn_level<=1, btn_press<=1;
//              btn_s=1 otherwise -> cnt++; btn_s=0 (bounce) -> STABLE_LO, cnt=0, no strobe.
//     STABLE_HI / WAIT_LO: mirror image; acceptance sets btn_level<=0, btn_release<=1.
//   - Latency: first edge sampling btn_raw=1 to btn_level=1 is exactly SYNC_STAGES+DEBOUNCE_CYCLES edges if input stays stable; same for release.
//   - Strobes are registered, high exactly one cycle; press and release never in same cycle.
//   - Counter width = $clog2(DEBOUNCE_CYCLES)+1; never wraps (cleared on every state change).
//   - Button held through reset: seen as fresh press after latency following rst deassert.
//   - Pulse shorter than DEBOUNCE_CYCLES synced cycles: fully ignored, no strobes.
// CONFIGURATION
//   Macro BUTTON_DEBOUNCE_LONG_PRESS_EN:
//   - Defined: hold counter runs while state==STABLE_HI, saturating; when it reaches LONG_CYCLES,
//     btn_long pulses one cycle; at most once per press; counter cleared on leaving STABLE_HI.
//   - Undefined: no hold counter synthesised; btn_long tied 0; LONG_CYCLES ignored.
// STRUCTURE
//   - Package debounce_pkg: state_t enum (STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO), 2-bit encoding
//     00/01/11/10, and shared width helper for counters.
//   - Sub-module sync_chain (param STAGES, 1-bit, sync reset to 0) instantiated once for btn_raw.
//   - Parameter legality (SYNC_STAGES>=2, DEBOUNCE_CYCLES>=2) checked by elaboration-time assertion.
// TESTING  (bench params SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=8)
//   1 Clean press: btn_raw 0->1 held -> btn_level=1 and btn_press=1 exactly 6 edges later, press low next cycle.
//   2 Bounce: btn_raw high 3 cycles, low 1, high 3, low -> btn_level stays 0, no strobes.
//   3 Clean release after accepted press: btn_raw 1->0 -> btn_level=0, btn_release=1 6 edges later, one cycle.
//   4 Reset mid-WAIT_HI: btn_raw=1, assert rst at cycle 4 for 1 cycle -> no strobe, outputs 0; btn still
//     held -> press accepted 6 edges after rst deasserts.
//   5 Long press (macro defined): hold 20 cycles after acceptance -> single btn_long pulse 8 cycles after
//     btn_press; macro undefined -> btn_long constant 0.
//   6 Glitch on stable high: btn_raw drops 2 cycles during hold -> btn_level stays 1, no release/press strobes.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the push-button conditioning logic.
// State encoding is Gray-ordered so the FSM steps through 00/01/11/10.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b11,
    WAIT_LO   = 2'b10
  } state_t;

  // Width for a counter that must hold the value n without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Single-bit multi-flop synchroniser for an asynchronous input.
// Output is the input delayed by STAGES clock edges; reset clears the chain.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronise, debounce, and emit level plus press/release strobes.
// Optional long-press strobe is compiled in with `define BUTTON_DEBOUNCE_LONG_PRESS_EN.
module button_debounce
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("button_debounce: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("button_debounce: DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_CYCLES < 1) begin : g_bad_long
    $error("button_debounce: LONG_CYCLES must be >= 1");
  end

  logic          btn_s;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          level_n, press_n, release_n;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (btn_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= STABLE_LO;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      btn_level   <= level_n;
      btn_press   <= press_n;
      btn_release <= release_n;
    end
  end

  // The counter only ever counts agreement with the candidate level; any state change clears it.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
    state_n = state;
    cnt_n   = cnt;
    case (state)
      STABLE_LO: begin
        if (btn_s) begin
          state_n = WAIT_HI;
          cnt_n   = CW'(1);
        end
      end
      WAIT_HI: begin
        if (!btn_s) begin
          state_n = STABLE_LO;
          cnt_n   = '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          state_n = STABLE_HI;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STABLE_HI: begin
        if (!btn_s) begin
          state_n = WAIT_LO;
          cnt_n   = CW'(1);
        end
      end
      WAIT_LO: begin
        if (btn_s) begin
          state_n = STABLE_HI;
          cnt_n   = '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          state_n = STABLE_LO;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = STABLE_LO;
        cnt_n   = '0;
      end
    endcase
  end

  // Level follows the accepted side; strobes fire only on an accepted transition, not on bounce.
  always_comb begin
    level_n   = (state_n == STABLE_HI) || (state_n == WAIT_LO);
    press_n   = (state == WAIT_HI) && (state_n == STABLE_HI);
    release_n = (state == WAIT_LO) && (state_n == STABLE_LO);
  end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int HW = cnt_width(LONG_CYCLES);

  logic [HW-1:0] hold_cnt;

  // Saturating at LONG_CYCLES makes the strobe fire once per stay in STABLE_HI.
  always_ff @(posedge clk) begin
    if (rst || (state != STABLE_HI)) begin
      hold_cnt <= '0;
      btn_long <= 1'b0;
    end else if (hold_cnt != HW'(LONG_CYCLES)) begin
      hold_cnt <= hold_cnt + HW'(1);
      btn_long <= (hold_cnt == HW'(LONG_CYCLES - 1));
    end else begin
      btn_long <= 1'b0;
    end
  end
`else
  assign btn_long = 1'b0;
`endif

endmodule
